spi_adc_responder: RTL and testbench
====================================

# spi_adc_responder

Cycle-level SPI responder that emulates the dual-channel 12-bit MCP3202-style ADC on the SPI_SCK / SPI_AD / SPI_DIN / SPI_DOUT link. It is the other end of the ADC controller. It decodes the start and configuration bits the controller shifts in, snapshots the requested channel, and shifts the 12-bit result back on MISO. It serves as the bench/loopback stand-in for the physical ADC, so the accelerator and CDS paths can be driven from DIP/registers or testbenches.

## Interface
- SYNC_STAGES, 2, synchronizer depth on spi_sck / spi_cs_n / spi_mosi (≥2)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- spi_sck  in  1  serial clock from initiator (idle low, mode 0,0)
- spi_cs_n  in  1  chip select, active low
- spi_mosi  in  1  command bits from initiator
- spi_miso  out  1  result bits to initiator
- spi_miso_oe  out  1  1 while responder drives MISO (CS low, from null bit onward)
- ch0_val  in  12  CH0 sample value (e.g. accelerator pot)
- ch1_val  in  12  CH1 sample value (e.g. CDS)
- conv_done  out  1  1-clk pulse when initiator samples B0 of MSB-first word
- frame_abort  out  1  1-clk pulse when CS rises before conv_done in a frame
- last_cfg  out  3  {SGL, ODD, MSBF} of last accepted command

## Operation
- All three SPI inputs pass through SYNC_STAGES flops; rise/fall of SCK detected on synchronized copy; CS rise/fall likewise.
- States: IDLE, WAIT_START, CFG, NULLB, DATA_M, DATA_L, HOLD.
- IDLE: CS fall -> WAIT_START.
- WAIT_START: on each SCK rise, sample MOSI; 0 ignored (leading zeros allowed), 1 -> CFG, bit count 0.
- CFG: three SCK rises capture SGL, ODD, MSBF in that order. On the third rise:
  - snapshot result into 12-bit shift register;
  - update last_cfg;
  - enter NULLB.
- Result arithmetic:
  - SGL=1: ODD ? ch1_val : ch0_val.
  - SGL=0, ODD=0: ch0−ch1 if ch0>ch1 else 0.
  - SGL=0, ODD=1: ch1−ch0 if ch1>ch0 else 0.
  - Compute in 13 bits; no wrap.
- NULLB: on next SCK fall, drive spi_miso=0 (null bit) and assert spi_miso_oe.
- DATA_M: on each of next 12 SCK falls, drive B11..B0 MSB-first.
  - conv_done pulses on the SCK rise following the fall that drove B0.
  - Then: MSBF=1 -> HOLD; MSBF=0 -> DATA_L.
- DATA_L: on next 11 SCK falls, drive B1..B11 (LSB-first repeat, B0 not repeated), then HOLD.
- HOLD: spi_miso=0, spi_miso_oe stays 1 until CS rises.
- CS rise in any state:
  - -> IDLE; spi_miso=0, spi_miso_oe=0, counters cleared.
  - If the state was WAIT_START after at least one SCK rise, or CFG, NULLB, or DATA_M before conv_done, pulse frame_abort.
  - CS rise in DATA_L or HOLD is normal; no abort.
- CS fall while not IDLE (glitch after sync): restart at WAIT_START.
- ch0_val/ch1_val changes after snapshot do not affect the word in flight.
- Reset: state IDLE; spi_miso=0, spi_miso_oe=0, conv_done=0, frame_abort=0, last_cfg=3'b000; shift register and counters 0.

## Timing
- Input sync latency: SYNC_STAGES clk cycles; edge detect +1. Requirement: SCK high and low phases each ≥ SYNC_STAGES+3 clk cycles.
- MISO update: registered; valid SYNC_STAGES+2 clk after the SCK fall at the pin. This must be before the next SCK rise, which the phase requirement guarantees.
- Snapshot: the same clk as the third CFG SCK rise is detected.
- conv_done / frame_abort: exactly 1 clk wide, registered; never both in the same cycle.
- SCK edges while CS high are ignored. An SCK rise and a CS rise detected in the same clk: CS wins; the SCK edge is discarded.

## Test plan
- Single-ended CH0: ch0=12'hA5C, command 1,1,0,1 (start,SGL,ODD=0,MSBF) -> MISO after null = 1010_0101_1100, conv_done one pulse, last_cfg=3'b101.
- CH1 LSB-repeat: ch1=12'h801, command 1,1,1,0 -> MISO 0 then 1000_0000_0001 then 0,0,0,0,0,0,0,0,0,0,1 (B1..B11), then 0; no frame_abort.
- Differential clamp: ch0=12'h100, ch1=12'h300, SGL=0/ODD=0 -> 12'h000. Same values with ODD=1 -> 12'h200.
- Leading zeros and snapshot: three 0 bits before start, ch0 changed 12'h111→12'hFFF two SCK cycles after snapshot -> word 12'h111.
- Abort: CS raised after 5 data bits -> frame_abort one pulse, no conv_done, spi_miso_oe=0 within SYNC_STAGES+2 clk. Next frame decodes normally.
- Async reset asserted mid DATA_M -> all outputs 0 immediately. After release with CS still low, a new CS fall is required before a command is accepted.

Source files
------------

// File: rtl/spi_adc_responder.sv
// spi_adc_responder: SPI-mode-0 responder emulating a dual-channel 12-bit
// MCP3202-style ADC. It decodes start/SGL/ODD/MSBF from the initiator,
// snapshots the selected (or differential) result and shifts it back on MISO.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   spi_sck/cs_n/mosi   raw SPI inputs from the initiator (synchronized here)
//   spi_miso            result bit stream (registered)
//   spi_miso_oe         high while the responder drives MISO
//   ch0_val, ch1_val    12-bit channel samples
//   conv_done           1-clk pulse when the initiator samples B0 (MSB-first)
//   frame_abort         1-clk pulse when CS rises before conv_done
//   last_cfg            {SGL, ODD, MSBF} of the last accepted command
module spi_adc_responder #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  input  logic [11:0] ch0_val,
  input  logic [11:0] ch1_val,
  output logic        conv_done,
  output logic        frame_abort,
  output logic [2:0]  last_cfg
);

  localparam int unsigned DW = 12;
  localparam int unsigned CW = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_START, S_CFG, S_NULLB, S_DATA_M, S_DATA_L, S_HOLD
  } state_t;

  // Synchronizers and registered edge detectors
  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic sck_prev_q, cs_prev_q;
  logic sck_rise_q, sck_fall_q, cs_rise_q, cs_fall_q, cs_lvl_q, mosi_q;
  logic sck_s, cs_s, mosi_s;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // CS chain resets low so a CS already held low at reset release is not
  // mistaken for a fresh falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
      sck_rise_q  <= 1'b0;
      sck_fall_q  <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_lvl_q    <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
      sck_rise_q  <= sck_s & ~sck_prev_q;
      sck_fall_q  <= ~sck_s & sck_prev_q;
      cs_rise_q   <= cs_s & ~cs_prev_q;
      cs_fall_q   <= ~cs_s & cs_prev_q;
      cs_lvl_q    <= cs_s;
      mosi_q      <= mosi_s;
    end
  end

  // Conversion result; differential modes clamp at zero instead of wrapping
  logic [12:0]   diff01_c, diff10_c;
  logic [DW-1:0] result_c;
  logic          sgl_q, sgl_d, odd_q, odd_d;

  always_comb begin
    diff01_c = {1'b0, ch0_val} - {1'b0, ch1_val};
    diff10_c = {1'b0, ch1_val} - {1'b0, ch0_val};
    if (sgl_q)      result_c = odd_q ? ch1_val : ch0_val;
    else if (odd_q) result_c = diff10_c[12] ? '0 : diff10_c[DW-1:0];
    else            result_c = diff01_c[12] ? '0 : diff01_c[DW-1:0];
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          seen_q, seen_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic          miso_q, miso_d, oe_q, oe_d;
  logic          conv_q, conv_d, abort_q, abort_d;
  logic [2:0]    last_cfg_q, last_cfg_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      seen_q     <= 1'b0;
      sgl_q      <= 1'b0;
      odd_q      <= 1'b0;
      shreg_q    <= '0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      conv_q     <= 1'b0;
      abort_q    <= 1'b0;
      last_cfg_q <= 3'b000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      sgl_q      <= sgl_d;
      odd_q      <= odd_d;
      shreg_q    <= shreg_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      conv_q     <= conv_d;
      abort_q    <= abort_d;
      last_cfg_q <= last_cfg_d;
    end
  end

  // Next-state and output logic; CS rise outranks CS fall outranks SCK edges
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    seen_d     = seen_q;
    sgl_d      = sgl_q;
    odd_d      = odd_q;
    shreg_d    = shreg_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    conv_d     = 1'b0;
    abort_d    = 1'b0;
    last_cfg_d = last_cfg_q;

    if (cs_rise_q) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      seen_d  = 1'b0;
      miso_d  = 1'b0;
      oe_d    = 1'b0;
      case (state_q)
        S_WAIT_START:             abort_d = seen_q;
        S_CFG, S_NULLB, S_DATA_M: abort_d = 1'b1;
        default:                  abort_d = 1'b0;
      endcase
    end else if (cs_fall_q) begin
      state_d = S_WAIT_START;
      cnt_d   = '0;
      seen_d  = 1'b0;
      miso_d  = 1'b0;
      oe_d    = 1'b0;
    end else if (!cs_lvl_q) begin
      case (state_q)
        S_WAIT_START: begin
          if (sck_rise_q) begin
            seen_d = 1'b1;
            if (mosi_q) begin
              state_d = S_CFG;
              cnt_d   = '0;
            end
          end
        end
        S_CFG: begin
          if (sck_rise_q) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(0)) sgl_d = mosi_q;
            else if (cnt_q == CW'(1)) odd_d = mosi_q;
            else begin
              // Third bit is MSBF; SGL/ODD are already registered
              shreg_d    = result_c;
              last_cfg_d = {sgl_q, odd_q, mosi_q};
              state_d    = S_NULLB;
              cnt_d      = '0;
            end
          end
        end
        S_NULLB: begin
          if (sck_fall_q) begin
            miso_d  = 1'b0;
            oe_d    = 1'b1;
            state_d = S_DATA_M;
            cnt_d   = '0;
          end
        end
        S_DATA_M: begin
          if (sck_fall_q && cnt_q < CW'(DW)) begin
            miso_d = shreg_q[CW'(DW-1) - cnt_q];
            cnt_d  = cnt_q + CW'(1);
          end else if (sck_rise_q && cnt_q == CW'(DW)) begin
            // Initiator has just sampled B0
            conv_d  = 1'b1;
            cnt_d   = '0;
            state_d = last_cfg_q[0] ? S_HOLD : S_DATA_L;
          end
        end
        S_DATA_L: begin
          if (sck_fall_q) begin
            if (cnt_q < CW'(DW-1)) begin
              miso_d = shreg_q[cnt_q + CW'(1)];
              cnt_d  = cnt_q + CW'(1);
            end else begin
              miso_d  = 1'b0;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD:  miso_d = 1'b0;
        default: ;
      endcase
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign conv_done   = conv_q;
  assign frame_abort = abort_q;
  assign last_cfg    = last_cfg_q;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Scoreboard bench for spi_adc_responder: the SPI driver queues the expected
// MISO bits of each frame; a monitor pops and compares on every SCK rise
// while the responder drives MISO.
module tb_spi_adc_responder;

  localparam int SYNC = 2;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst, spi_sck, spi_cs_n, spi_mosi;
  logic        spi_miso, spi_miso_oe, conv_done, frame_abort;
  logic [11:0] ch0_val, ch1_val;
  logic [2:0]  last_cfg;

  int compares = 0;
  int errors   = 0;
  int conv_cnt = 0;
  int abort_cnt = 0;
  int bit_no   = 0;
  logic exp_q[$];

  spi_adc_responder #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .ch0_val(ch0_val), .ch1_val(ch1_val), .conv_done(conv_done),
    .frame_abort(frame_abort), .last_cfg(last_cfg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compares++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // MISO monitor: initiator samples on SCK rise
  always @(posedge spi_sck) begin
    if (spi_miso_oe === 1'b1) begin
      if (exp_q.size() == 0) begin
        compares++;
        errors++;
        $display("FAIL miso_unexpected: got oe=1 miso=%b expected no drive at %0t", spi_miso, $time);
      end else begin
        logic e;
        e = exp_q.pop_front();
        chk($sformatf("miso_bit%0d", bit_no), 32'(spi_miso), 32'(e));
      end
      bit_no++;
    end
  end

  // Pulse monitor
  always @(negedge clk) begin
    if (conv_done === 1'b1)   conv_cnt++;
    if (frame_abort === 1'b1) abort_cnt++;
    if (conv_done === 1'b1 && frame_abort === 1'b1) begin
      compares++;
      errors++;
      $display("FAIL pulse_overlap: got conv_done=1 frame_abort=1 expected not both at %0t", $time);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SPI frame: optional CS fall, ncmd command bits then nresp+nextra
  // further clocks; the nresp expected MISO bits are queued up front.
  task automatic frame(input logic [31:0] cmd, input int ncmd,
                       input logic [31:0] resp, input int nresp, input int nextra,
                       input bit fall_cs, input bit rise_cs,
                       input int chg_at, input logic [11:0] chg_val);
    for (int i = nresp - 1; i >= 0; i--) exp_q.push_back(resp[i]);
    bit_no = 0;
    if (fall_cs) spi_cs_n = 1'b0;
    wait_clk(HALF);
    for (int k = 0; k < ncmd + nresp + nextra; k++) begin
      spi_mosi = (k < ncmd) ? cmd[ncmd-1-k] : 1'b0;
      if (k == chg_at) ch0_val = chg_val;
      wait_clk(HALF);
      spi_sck = 1'b1;
      wait_clk(HALF);
      spi_sck = 1'b0;
    end
    wait_clk(HALF);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    if (rise_cs) begin
      spi_cs_n = 1'b1;
      wait_clk(SYNC + 2);
      chk("oe_off_after_cs", 32'(spi_miso_oe), 32'd0);
      chk("miso_off_after_cs", 32'(spi_miso), 32'd0);
      wait_clk(6);
    end
  endtask

  task automatic check_frame(input string name, input int c0, input int a0,
                             input int exp_conv, input int exp_abort, input logic [2:0] exp_cfg);
    chk({name, "_conv_done"}, 32'(conv_cnt - c0), 32'(exp_conv));
    chk({name, "_frame_abort"}, 32'(abort_cnt - a0), 32'(exp_abort));
    chk({name, "_last_cfg"}, 32'(last_cfg), 32'(exp_cfg));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int c0, a0;
    rst = 1'b1; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    ch0_val = 12'h000; ch1_val = 12'h000;
    wait_clk(3);
    chk("rst_miso", 32'(spi_miso), 32'd0);
    chk("rst_oe", 32'(spi_miso_oe), 32'd0);
    chk("rst_conv", 32'(conv_done), 32'd0);
    chk("rst_abort", 32'(frame_abort), 32'd0);
    chk("rst_cfg", 32'(last_cfg), 32'd0);
    rst = 1'b0;
    wait_clk(10);

    // Single-ended CH0, MSB-first only
    ch0_val = 12'hA5C; ch1_val = 12'h3C3;
    c0 = conv_cnt; a0 = abort_cnt;
    frame(32'b1101, 4, {18'd0, 1'b0, 12'hA5C, 1'b0}, 14, 0, 1, 1, -1, 12'h0);
    check_frame("ch0", c0, a0, 1, 0, 3'b101);

    // CH1 with LSB-first repeat of B1..B11
    ch1_val = 12'h801;
    c0 = conv_cnt; a0 = abort_cnt;
    frame(32'b1110, 4, {7'd0, 1'b0, 12'h801, 11'b00000000001, 1'b0}, 25, 0, 1, 1, -1, 12'h0);
    check_frame("ch1_lsb", c0, a0, 1, 0, 3'b110);

    // Differential clamp and positive difference
    ch0_val = 12'h100; ch1_val = 12'h300;
    c0 = conv_cnt; a0 = abort_cnt;
    frame(32'b1001, 4, {18'd0, 1'b0, 12'h000, 1'b0}, 14, 0, 1, 1, -1, 12'h0);
    check_frame("diff_clamp", c0, a0, 1, 0, 3'b001);
    c0 = conv_cnt; a0 = abort_cnt;
    frame(32'b1011, 4, {18'd0, 1'b0, 12'h200, 1'b0}, 14, 0, 1, 1, -1, 12'h0);
    check_frame("diff_pos", c0, a0, 1, 0, 3'b011);

    // Leading zeros; ch0 changes two SCK cycles after the snapshot
    ch0_val = 12'h111;
    c0 = conv_cnt; a0 = abort_cnt;
    frame(32'b0001101, 7, {18'd0, 1'b0, 12'h111, 1'b0}, 14, 0, 1, 1, 8, 12'hFFF);
    check_frame("lead_zero", c0, a0, 1, 0, 3'b101);

    // Abort after null + 5 data bits of 0xA5C
    ch0_val = 12'hA5C;
    c0 = conv_cnt; a0 = abort_cnt;
    frame(32'b1101, 4, 32'b010100, 6, 0, 1, 1, -1, 12'h0);
    check_frame("abort", c0, a0, 0, 1, 3'b101);

    // Next frame decodes normally
    c0 = conv_cnt; a0 = abort_cnt;
    frame(32'b1101, 4, {18'd0, 1'b0, 12'hA5C, 1'b0}, 14, 0, 1, 1, -1, 12'h0);
    check_frame("post_abort", c0, a0, 1, 0, 3'b101);

    // Async reset mid DATA_M (null + B11..B9 sampled), CS kept low
    frame(32'b1101, 4, 32'b0101, 4, 0, 1, 0, -1, 12'h0);
    chk("oe_before_rst", 32'(spi_miso_oe), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_miso", 32'(spi_miso), 32'd0);
    chk("midrst_oe", 32'(spi_miso_oe), 32'd0);
    chk("midrst_conv", 32'(conv_done), 32'd0);
    chk("midrst_abort", 32'(frame_abort), 32'd0);
    chk("midrst_cfg", 32'(last_cfg), 32'd0);
    wait_clk(3);
    rst = 1'b0;
    wait_clk(4);

    // CS still low with no new fall: command must be ignored
    c0 = conv_cnt; a0 = abort_cnt;
    frame(32'b1101, 4, 32'd0, 0, 14, 0, 1, -1, 12'h0);
    check_frame("no_cs_fall", c0, a0, 0, 0, 3'b000);

    // Fresh frame after reset decodes normally
    ch0_val = 12'h100; ch1_val = 12'h300;
    c0 = conv_cnt; a0 = abort_cnt;
    frame(32'b1011, 4, {18'd0, 1'b0, 12'h200, 1'b0}, 14, 0, 1, 1, -1, 12'h0);
    check_frame("post_rst", c0, a0, 1, 0, 3'b011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
